// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Turns the ASCII character stream from the UART receiver into 34-bit
//   command words for the WB_master command port.
//   Line syntax: <letter><hex digits><CR|LF>
//     A<1-8 hex>  -> {2'b10, 2'b00, addr[29:0]}  (address set)
//     W<1-8 hex>  -> {2'b01, data[31:0]}         (write)
//     R           -> {2'b00, 32'h0}              (read)
//   Ports:
//     i_clk       system clock, rising edge
//     i_reset     asynchronous active-high reset
//     i_stb       one-cycle strobe, i_char valid
//     i_char      received ASCII character
//     o_cmd_stb   command word valid (held until accepted)
//     o_cmd_word  command word, stable while o_cmd_stb is high
//     i_cmd_busy  downstream busy, blocks acceptance
//     o_err       one-cycle pulse: malformed command discarded
//     o_overrun   one-cycle pulse: character dropped while a word was pending
module uart_cmd_decoder #(
  parameter bit LOWER_OK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [7:0]  i_char,
  output logic        o_cmd_stb,
  output logic [33:0] o_cmd_word,
  input  logic        i_cmd_busy,
  output logic        o_err,
  output logic        o_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_HEX, S_SKIP, S_SEND} state_t;

  // Opcode encoding doubles as the command word's top two bits.
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADDR  = 2'b10;

  state_t      r_state, w_state_next;
  logic [1:0]  r_op, w_op_next;
  logic [31:0] r_acc, w_acc_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_cmd_stb, w_cmd_stb_next;
  logic [33:0] r_cmd_word, w_cmd_word_next;
  logic        r_err, w_err_next;
  logic        r_overrun, w_overrun_next;

  // Character classification
  logic        w_is_hex, w_is_term, w_is_space, w_is_letter;
  logic [3:0]  w_nibble;
  logic [1:0]  w_letter_op;
  logic [33:0] w_word;

  always_comb begin
    w_is_hex    = 1'b0;
    w_nibble    = 4'd0;
    w_is_letter = 1'b0;
    w_letter_op = OP_READ;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nibble = i_char[3:0];
    end else if (i_char >= 8'h41 && i_char <= 8'h46) begin
      // 'A'..'F' have low nibble 1..6, so +9 yields 10..15
      w_is_hex = 1'b1;
      w_nibble = i_char[3:0] + 4'd9;
    end else if (LOWER_OK && i_char >= 8'h61 && i_char <= 8'h66) begin
      w_is_hex = 1'b1;
      w_nibble = i_char[3:0] + 4'd9;
    end
    if (i_char == 8'h41 || (LOWER_OK && i_char == 8'h61)) begin
      w_is_letter = 1'b1;
      w_letter_op = OP_ADDR;
    end else if (i_char == 8'h57 || (LOWER_OK && i_char == 8'h77)) begin
      w_is_letter = 1'b1;
      w_letter_op = OP_WRITE;
    end else if (i_char == 8'h52 || (LOWER_OK && i_char == 8'h72)) begin
      w_is_letter = 1'b1;
      w_letter_op = OP_READ;
    end
  end

  assign w_is_term  = (i_char == 8'h0D) || (i_char == 8'h0A);
  assign w_is_space = (i_char == 8'h20);

  // Address keeps only acc[29:0]; upper digits beyond 30 bits are dropped.
  always_comb begin
    case (r_op)
      OP_ADDR:  w_word = {OP_ADDR, 2'b00, r_acc[29:0]};
      OP_WRITE: w_word = {OP_WRITE, r_acc};
      default:  w_word = {OP_READ, 32'h0};
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_op_next       = r_op;
    w_acc_next      = r_acc;
    w_cnt_next      = r_cnt;
    w_cmd_stb_next  = r_cmd_stb;
    w_cmd_word_next = r_cmd_word;
    w_err_next      = 1'b0;
    w_overrun_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_stb) begin
          if (w_is_term || w_is_space) begin
            // blank lines and the LF of a CRLF pair are harmless
          end else if (w_is_letter) begin
            w_op_next    = w_letter_op;
            w_acc_next   = 32'h0;
            w_cnt_next   = 4'd0;
            w_state_next = S_HEX;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_SKIP;
          end
        end
      end
      S_HEX: begin
        if (i_stb) begin
          if (w_is_hex) begin
            if (r_op != OP_READ && r_cnt < 4'd8) begin
              w_acc_next = {r_acc[27:0], w_nibble};
              w_cnt_next = r_cnt + 4'd1;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = S_SKIP;
            end
          end else if (w_is_term) begin
            if (r_op != OP_READ && r_cnt == 4'd0) begin
              // terminator already seen, so resume at IDLE rather than SKIP
              w_err_next   = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_cmd_word_next = w_word;
              w_cmd_stb_next  = 1'b1;
              w_state_next    = S_SEND;
            end
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (i_stb && w_is_term) begin
          w_state_next = S_IDLE;
        end
      end
      S_SEND: begin
        // No buffering: anything arriving while a word is pending is lost,
        // including on the cycle the word is accepted.
        if (i_stb) begin
          w_overrun_next = 1'b1;
        end
        if (r_cmd_stb && !i_cmd_busy) begin
          w_cmd_stb_next = 1'b0;
          w_state_next   = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_READ;
      r_acc      <= 32'h0;
      r_cnt      <= 4'd0;
      r_cmd_stb  <= 1'b0;
      r_cmd_word <= 34'h0;
      r_err      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_op       <= w_op_next;
      r_acc      <= w_acc_next;
      r_cnt      <= w_cnt_next;
      r_cmd_stb  <= w_cmd_stb_next;
      r_cmd_word <= w_cmd_word_next;
      r_err      <= w_err_next;
      r_overrun  <= w_overrun_next;
    end
  end

  assign o_cmd_stb  = r_cmd_stb;
  assign o_cmd_word = r_cmd_word;
  assign o_err      = r_err;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: drives character strings, watches
// the command port, and checks words, error and overrun pulses.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [7:0]  chr;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        busy;
  logic        err;
  logic        ovr;

  uart_cmd_decoder #(.LOWER_OK(1'b1)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_stb      (stb),
    .i_char     (chr),
    .o_cmd_stb  (cmd_stb),
    .o_cmd_word (cmd_word),
    .i_cmd_busy (busy),
    .o_err      (err),
    .o_overrun  (ovr)
  );

  always #5 clk = ~clk;

  // Observer: counts high cycles of the pulse outputs and records every
  // accepted word. Sampled on the falling edge, away from input changes.
  int          n_err_cyc = 0;
  int          n_ovr_cyc = 0;
  int          n_words   = 0;
  logic [33:0] words [0:63];

  always @(negedge clk) begin
    if (err) n_err_cyc <= n_err_cyc + 1;
    if (ovr) n_ovr_cyc <= n_ovr_cyc + 1;
    if (cmd_stb && !busy && !rst && n_words < 64) begin
      words[n_words] <= cmd_word;
      n_words        <= n_words + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobed character followed by one quiet cycle.
  task automatic send_char(input logic [7:0] c);
    @(posedge clk); #1;
    stb = 1'b1;
    chr = c;
    @(posedge clk); #1;
    stb = 1'b0;
    chr = 8'h00;
    tick(1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  int e0, o0, w0;

  initial begin
    rst  = 1'b1;
    stb  = 1'b0;
    chr  = 8'h00;
    busy = 1'b0;
    tick(3);
    // reset state
    chk("rst_stb",  {33'h0, cmd_stb}, 34'h0);
    chk("rst_word", cmd_word, 34'h0);
    chk("rst_err",  {33'h0, err}, 34'h0);
    chk("rst_ovr",  {33'h0, ovr}, 34'h0);
    rst = 1'b0;
    tick(2);

    // "A1\n": stb rises right after the terminator edge, lasts one cycle
    e0 = n_err_cyc; w0 = n_words;
    send_str("A1");
    @(posedge clk); #1;
    stb = 1'b1; chr = 8'h0A;
    @(posedge clk); #1;
    stb = 1'b0; chr = 8'h00;
    chk("a1_latency_stb", {33'h0, cmd_stb}, 34'h1);
    chk("a1_latency_word", cmd_word, 34'h2_0000_0001);
    tick(1);
    chk("a1_stb_width", {33'h0, cmd_stb}, 34'h0);
    tick(1);
    chk("a1_count", 34'(n_words - w0), 34'd1);
    chk("a1_word", words[w0], 34'h2_0000_0001);
    chk("a1_no_err", 34'(n_err_cyc - e0), 34'd0);

    // "W5\r\n" then lowercase "r\n"
    e0 = n_err_cyc; w0 = n_words;
    send_str("W5\r\n");
    send_str("r\n");
    tick(2);
    chk("w5r_count", 34'(n_words - w0), 34'd2);
    chk("w5_word", words[w0], 34'h1_0000_0005);
    chk("r_word", words[w0 + 1], 34'h0_0000_0000);
    chk("w5r_no_err", 34'(n_err_cyc - e0), 34'd0);

    // address truncation, too many digits, recovery
    e0 = n_err_cyc; w0 = n_words;
    send_str("AFFFFFFFF\n");
    tick(2);
    chk("afull_count", 34'(n_words - w0), 34'd1);
    chk("afull_word", words[w0], 34'h2_3FFF_FFFF);
    w0 = n_words;
    send_str("W123456789\n");
    tick(2);
    chk("w9dig_err", 34'(n_err_cyc - e0), 34'd1);
    chk("w9dig_no_word", 34'(n_words - w0), 34'd0);
    send_str("W7\n");
    tick(2);
    chk("w7_count", 34'(n_words - w0), 34'd1);
    chk("w7_word", words[w0], 34'h1_0000_0007);

    // malformed lines: missing digits, digits after R, unknown letter
    e0 = n_err_cyc; w0 = n_words;
    send_str("W\n");
    send_str("R3\n");
    send_str("X12\n");
    tick(2);
    chk("bad_err", 34'(n_err_cyc - e0), 34'd3);
    chk("bad_no_word", 34'(n_words - w0), 34'd0);
    send_str("A2\n");
    tick(2);
    chk("a2_count", 34'(n_words - w0), 34'd1);
    chk("a2_word", words[w0], 34'h2_0000_0002);

    // backpressure with a character injected during the wait
    o0 = n_ovr_cyc; w0 = n_words;
    busy = 1'b1;
    send_str("WDEADBEEF\n");
    chk("busy_stb", {33'h0, cmd_stb}, 34'h1);
    chk("busy_word", cmd_word, 34'h1_DEAD_BEEF);
    tick(5);
    send_char(8'h5A);
    tick(12);
    chk("busy_ovr", 34'(n_ovr_cyc - o0), 34'd1);
    chk("busy_stb_hold", {33'h0, cmd_stb}, 34'h1);
    chk("busy_word_hold", cmd_word, 34'h1_DEAD_BEEF);
    chk("busy_no_xfer", 34'(n_words - w0), 34'd0);
    busy = 1'b0;
    tick(1);
    chk("release_stb", {33'h0, cmd_stb}, 34'h0);
    chk("release_count", 34'(n_words - w0), 34'd1);
    chk("release_word", words[w0], 34'h1_DEAD_BEEF);

    // async reset in the middle of "W12"
    send_str("W1");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_hex_stb", {33'h0, cmd_stb}, 34'h0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // async reset while a word is pending
    busy = 1'b1;
    send_str("W9\n");
    chk("send_pending", {33'h0, cmd_stb}, 34'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_send_stb", {33'h0, cmd_stb}, 34'h0);
    chk("rst_send_word", cmd_word, 34'h0);
    tick(1);
    rst  = 1'b0;
    busy = 1'b0;
    tick(1);

    w0 = n_words;
    send_str("A1\n");
    tick(2);
    chk("post_rst_count", 34'(n_words - w0), 34'd1);
    chk("post_rst_word", words[w0], 34'h2_0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
